// File: rtl/lbuf_wr_ctrl.sv
// Write-side controller for the circular line buffer: tracks source sync timing, turns the
// captured pixel window into line-buffer writes and flags write/read line collisions.
module lbuf_wr_ctrl #(
    parameter int unsigned NUM_LINE_BUFFERS = 40,
    parameter int unsigned DATA_W           = 12,
    parameter int unsigned H_CNT_W          = 9,
    parameter int unsigned V_CNT_W          = 9
) (
    input  logic               PCLK,
    input  logic               reset,
    input  logic               pix_en,
    input  logic               HSYNC_src,
    input  logic               VSYNC_src,
    input  logic [DATA_W-1:0]  pixel_in,
    input  logic [H_CNT_W-1:0] h_start,
    input  logic [H_CNT_W-1:0] h_active,
    input  logic [V_CNT_W-1:0] v_start,
    input  logic [V_CNT_W-1:0] v_active,
    input  logic [5:0]         rd_line,
    output logic               wr_en,
    output logic [5:0]         wr_line,
    output logic [H_CNT_W-1:0] wr_pixel,
    output logic [DATA_W-1:0]  wr_data,
    output logic               frame_start,
    output logic               collision,
    output logic               busy
);

    localparam logic [5:0] LastLine = 6'(NUM_LINE_BUFFERS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StVblank,
        StActive,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic               prev_hs_q, prev_hs_d;
    logic               prev_vs_q, prev_vs_d;
    logic [H_CNT_W-1:0] hcnt_q, hcnt_d;
    logic [V_CNT_W-1:0] vcnt_q, vcnt_d;

    logic [H_CNT_W-1:0] h_start_q, h_start_d;
    logic [H_CNT_W-1:0] h_active_q, h_active_d;
    logic [V_CNT_W-1:0] v_start_q, v_start_d;
    logic [V_CNT_W-1:0] v_active_q, v_active_d;

    logic [5:0]         wr_line_q, wr_line_d;
    logic               wr_en_q, wr_en_d;
    logic [H_CNT_W-1:0] wr_pixel_q, wr_pixel_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic               frame_start_q, frame_start_d;
    logic               collision_q, collision_d;
    logic               busy_q, busy_d;

    logic             hs_fall;
    logic             vs_fall;
    logic             line_adv;
    logic             in_window;
    logic             capture;
    logic [V_CNT_W:0] v_last;
    logic [H_CNT_W:0] h_end;

    // Sync inputs are only meaningful on pixel strobes.
    assign hs_fall = pix_en & prev_hs_q & ~HSYNC_src;
    assign vs_fall = pix_en & prev_vs_q & ~VSYNC_src;

    assign v_last = {1'b0, v_start_q} + {1'b0, v_active_q} - 1'b1;
    assign h_end  = {1'b0, h_start_q} + {1'b0, h_active_q};

    always_comb begin
        prev_hs_d = pix_en ? HSYNC_src : prev_hs_q;
        prev_vs_d = pix_en ? VSYNC_src : prev_vs_q;

        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (vs_fall) begin
            hcnt_d = '0;
            vcnt_d = '0;
        end else if (hs_fall) begin
            hcnt_d = '0;
            if (vcnt_q != '1) begin
                vcnt_d = vcnt_q + 1'b1;
            end
        end else if (pix_en && (hcnt_q != '1)) begin
            hcnt_d = hcnt_q + 1'b1;
        end

        h_start_d  = vs_fall ? h_start  : h_start_q;
        h_active_d = vs_fall ? h_active : h_active_q;
        v_start_d  = vs_fall ? v_start  : v_start_q;
        v_active_d = vs_fall ? v_active : v_active_q;
    end

    always_comb begin
        state_d   = state_q;
        wr_line_d = wr_line_q;
        line_adv  = 1'b0;
        if (vs_fall) begin
            // A new frame always restarts from vertical blanking, abandoning any partial line.
            state_d = StVblank;
        end else if (hs_fall) begin
            unique case (state_q)
                StVblank: begin
                    if (vcnt_d == v_start_q) begin
                        if (v_active_q == '0) begin
                            state_d = StDone;
                        end else begin
                            state_d   = StActive;
                            wr_line_d = '0;
                        end
                    end
                end
                StActive: begin
                    if ({1'b0, vcnt_q} == v_last) begin
                        state_d = StDone;
                    end else begin
                        line_adv  = 1'b1;
                        wr_line_d = (wr_line_q == LastLine) ? 6'd0 : wr_line_q + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The window is checked against the count of the pixel sampled this strobe.
    assign in_window = ({1'b0, hcnt_d} >= {1'b0, h_start_q}) && ({1'b0, hcnt_d} < h_end);
    assign capture   = pix_en && (state_d == StActive) && in_window;

    always_comb begin
        wr_en_d       = capture;
        wr_pixel_d    = capture ? (hcnt_d - h_start_q) : wr_pixel_q;
        wr_data_d     = capture ? pixel_in : wr_data_q;
        frame_start_d = vs_fall;
        busy_d        = (state_d == StActive);
        collision_d   = collision_q;
        if (vs_fall) begin
            collision_d = 1'b0;
        end else if (line_adv && (wr_line_d == rd_line)) begin
            collision_d = 1'b1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (reset) begin
            state_q       <= StIdle;
            prev_hs_q     <= 1'b1;
            prev_vs_q     <= 1'b1;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            h_start_q     <= '0;
            h_active_q    <= '0;
            v_start_q     <= '0;
            v_active_q    <= '0;
            wr_line_q     <= '0;
            wr_en_q       <= 1'b0;
            wr_pixel_q    <= '0;
            wr_data_q     <= '0;
            frame_start_q <= 1'b0;
            collision_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_hs_q     <= prev_hs_d;
            prev_vs_q     <= prev_vs_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            h_start_q     <= h_start_d;
            h_active_q    <= h_active_d;
            v_start_q     <= v_start_d;
            v_active_q    <= v_active_d;
            wr_line_q     <= wr_line_d;
            wr_en_q       <= wr_en_d;
            wr_pixel_q    <= wr_pixel_d;
            wr_data_q     <= wr_data_d;
            frame_start_q <= frame_start_d;
            collision_q   <= collision_d;
            busy_q        <= busy_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_line     = wr_line_q;
    assign wr_pixel    = wr_pixel_q;
    assign wr_data     = wr_data_q;
    assign frame_start = frame_start_q;
    assign collision   = collision_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_lbuf_wr_ctrl.sv
// Randomized bench for lbuf_wr_ctrl: a frame-level model predicts every output each cycle,
// and directed frames pin the model with hand-computed totals.
module tb_lbuf_wr_ctrl;

    localparam int NLB = 40;
    localparam int DW  = 12;
    localparam int HW  = 9;
    localparam int VW  = 9;

    logic          PCLK      = 1'b0;
    logic          reset     = 1'b1;
    logic          pix_en    = 1'b0;
    logic          HSYNC_src = 1'b1;
    logic          VSYNC_src = 1'b1;
    logic [DW-1:0] pixel_in  = '0;
    logic [HW-1:0] h_start   = '0;
    logic [HW-1:0] h_active  = '0;
    logic [VW-1:0] v_start   = '0;
    logic [VW-1:0] v_active  = '0;
    logic [5:0]    rd_line   = '0;

    logic          wr_en;
    logic [5:0]    wr_line;
    logic [HW-1:0] wr_pixel;
    logic [DW-1:0] wr_data;
    logic          frame_start;
    logic          collision;
    logic          busy;

    lbuf_wr_ctrl #(
        .NUM_LINE_BUFFERS(NLB),
        .DATA_W          (DW),
        .H_CNT_W         (HW),
        .V_CNT_W         (VW)
    ) dut (
        .PCLK       (PCLK),
        .reset      (reset),
        .pix_en     (pix_en),
        .HSYNC_src  (HSYNC_src),
        .VSYNC_src  (VSYNC_src),
        .pixel_in   (pixel_in),
        .h_start    (h_start),
        .h_active   (h_active),
        .v_start    (v_start),
        .v_active   (v_active),
        .rd_line    (rd_line),
        .wr_en      (wr_en),
        .wr_line    (wr_line),
        .wr_pixel   (wr_pixel),
        .wr_data    (wr_data),
        .frame_start(frame_start),
        .collision  (collision),
        .busy       (busy)
    );

    always #5 PCLK = ~PCLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level model: line/pixel indices counted from the sync edges, active lines found by
    // range, and the buffer line derived as (line - v_start) mod depth.
    bit m_prev_hs = 1, m_prev_vs = 1, m_framed = 0;
    int m_hcnt = 0, m_vcnt = 0;
    int m_hs = 0, m_ha = 0, m_vs = 0, m_va = 0;
    int m_wr_en = 0, m_wr_line = 0, m_wr_pixel = 0, m_wr_data = 0;
    int m_fs = 0, m_coll = 0, m_busy = 0, m_wr_cnt = 0;

    function automatic bit line_active();
        return m_framed && (m_vs >= 1) && (m_vcnt >= m_vs) && (m_vcnt < m_vs + m_va);
    endfunction

    task automatic model_step();
        bit hf, vf, act;
        int nl;
        if (reset) begin
            m_prev_hs = 1; m_prev_vs = 1; m_framed = 0;
            m_hcnt = 0; m_vcnt = 0; m_hs = 0; m_ha = 0; m_vs = 0; m_va = 0;
            m_wr_en = 0; m_wr_line = 0; m_wr_pixel = 0; m_wr_data = 0;
            m_fs = 0; m_coll = 0; m_busy = 0;
            return;
        end
        m_wr_en = 0;
        m_fs    = 0;
        if (pix_en) begin
            hf = m_prev_hs && !HSYNC_src;
            vf = m_prev_vs && !VSYNC_src;
            m_prev_hs = HSYNC_src;
            m_prev_vs = VSYNC_src;
            if (vf) begin
                m_hs = int'(h_start); m_ha = int'(h_active);
                m_vs = int'(v_start); m_va = int'(v_active);
                m_hcnt = 0; m_vcnt = 0; m_framed = 1; m_fs = 1; m_coll = 0;
            end else if (hf) begin
                m_vcnt = (m_vcnt < 511) ? m_vcnt + 1 : 511;
                m_hcnt = 0;
            end else begin
                m_hcnt = (m_hcnt < 511) ? m_hcnt + 1 : 511;
            end
            act = line_active();
            if (hf && !vf && act) begin
                nl = (m_vcnt - m_vs) % NLB;
                if (m_vcnt != m_vs && nl == int'(rd_line)) m_coll = 1;
                m_wr_line = nl;
            end
            if (act && m_hcnt >= m_hs && m_hcnt < m_hs + m_ha) begin
                m_wr_en = 1;
                m_wr_pixel = m_hcnt - m_hs;
                m_wr_data = int'(pixel_in);
                m_wr_cnt++;
            end
        end
        m_busy = line_active();
    endtask

    initial forever begin
        @(posedge PCLK);
        model_step();
    end

    int d_wr_cnt = 0, d_fs_cnt = 0, d_busy_cnt = 0;

    initial forever begin
        @(negedge PCLK);
        chk("wr_en", 32'(wr_en), m_wr_en);
        chk("wr_line", 32'(wr_line), m_wr_line);
        chk("wr_pixel", 32'(wr_pixel), m_wr_pixel);
        chk("wr_data", 32'(wr_data), m_wr_data);
        chk("frame_start", 32'(frame_start), m_fs);
        chk("collision", 32'(collision), m_coll);
        chk("busy", 32'(busy), m_busy);
        if (wr_en === 1'b1) d_wr_cnt++;
        if (frame_start === 1'b1) d_fs_cnt++;
        if (busy === 1'b1) d_busy_cnt++;
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, ".wr_en"}, 32'(wr_en), 0);
        chk({tag, ".wr_line"}, 32'(wr_line), 0);
        chk({tag, ".wr_pixel"}, 32'(wr_pixel), 0);
        chk({tag, ".wr_data"}, 32'(wr_data), 0);
        chk({tag, ".frame_start"}, 32'(frame_start), 0);
        chk({tag, ".collision"}, 32'(collision), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
    endtask

    // One pixel strobe followed by (per-1) idle cycles carrying junk on the sync lines.
    task automatic step(input logic hs, input logic vs, input int per, input bit do_rst);
        pix_en = 1'b1; HSYNC_src = hs; VSYNC_src = vs; pixel_in = DW'($urandom); reset = do_rst;
        @(negedge PCLK);
        if (do_rst) begin
            #1;
            chk_all_zero("mid_reset");
            reset = 1'b0;
        end
        for (int i = 1; i < per; i++) begin
            pix_en = 1'b0;
            HSYNC_src = 1'($urandom); VSYNC_src = 1'($urandom); pixel_in = DW'($urandom);
            @(negedge PCLK);
        end
    endtask

    task automatic frame(input int per, input int hs, input int ha, input int vs, input int va,
                         input int htot, input int vtot, input int rd, input int rst_line,
                         input bit scramble);
        h_start = HW'(hs); h_active = HW'(ha); v_start = VW'(vs); v_active = VW'(va);
        rd_line = 6'(rd);
        for (int l = 0; l < vtot; l++) begin
            for (int p = 0; p < htot; p++) begin
                if (scramble && l == 1 && p == 0) begin
                    h_start = HW'($urandom); h_active = HW'($urandom);
                    v_start = VW'($urandom); v_active = VW'($urandom);
                end
                step((p < 2) ? 1'b0 : 1'b1, (l == 0) ? 1'b0 : 1'b1, per, (l == rst_line && p == 12));
            end
        end
        #1;
    endtask

    int b_wr, b_fs, b_busy, b_m;

    task automatic mark();
        b_wr = d_wr_cnt; b_fs = d_fs_cnt; b_busy = d_busy_cnt; b_m = m_wr_cnt;
    endtask

    task automatic chk_counts(input string tag, input int wr, input int fs, input int bsy);
        chk({tag, ".wr_count"}, d_wr_cnt - b_wr, wr);
        chk({tag, ".model_wr_count"}, m_wr_cnt - b_m, wr);
        chk({tag, ".frame_start_count"}, d_fs_cnt - b_fs, fs);
        chk({tag, ".busy_cycles"}, d_busy_cnt - b_busy, bsy);
    endtask

    initial begin
        int per, hs, ha, vs, va, htot, vtot;
        repeat (3) @(negedge PCLK);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;

        // 12 writes over wr_line 0..2, busy for lines 2..4 (3 lines x 20 cycles).
        mark(); frame(1, 10, 4, 2, 3, 20, 8, 0, -1, 0); chk_counts("s1", 12, 1, 60);
        chk("s1.final_wr_line", 32'(wr_line), 2);
        mark(); frame(1, 10, 4, 2, 3, 20, 8, 0, -1, 1); chk_counts("s1b", 12, 1, 60);
        mark(); frame(4, 10, 4, 2, 3, 20, 8, 0, -1, 0); chk_counts("s4", 12, 1, 240);

        // Reset at pixel 12 of line 3: line 2 (4 writes) + pixels 10,11 of line 3.
        mark(); frame(1, 10, 4, 2, 3, 20, 8, 0, 3, 0); chk_counts("rst", 6, 1, 32);
        mark(); frame(1, 10, 4, 2, 3, 20, 8, 0, -1, 0); chk_counts("after_rst", 12, 1, 60);

        // 45 lines wrap the pointer to 4 and hit rd_line=5 on the way.
        mark(); frame(1, 2, 3, 1, 45, 10, 47, 5, -1, 0); chk_counts("wrap", 135, 1, 450);
        chk("wrap.wr_line", 32'(wr_line), 4);
        chk("wrap.collision", 32'(collision), 1);
        chk("wrap.model_collision", m_coll, 1);

        mark(); frame(2, 2, 3, 1, 0, 10, 6, 0, -1, 0); chk_counts("va0", 0, 1, 0);
        chk("va0.collision", 32'(collision), 0);

        // Frame cut after active line index 2 of 10; next vs_fall lands on an hs_fall.
        mark(); frame(1, 3, 4, 2, 10, 12, 5, 30, -1, 0); chk_counts("abort", 12, 1, 36);
        chk("abort.wr_line", 32'(wr_line), 2);
        chk("abort.busy", 32'(busy), 1);
        mark(); frame(1, 10, 4, 2, 3, 20, 8, 0, -1, 0); chk_counts("post_abort", 12, 1, 60);
        chk("post_abort.wr_line", 32'(wr_line), 2);

        for (int f = 0; f < 10; f++) begin
            per  = $urandom_range(1, 3);
            hs   = $urandom_range(0, 8);
            ha   = $urandom_range(1, 8);
            vs   = $urandom_range(1, 4);
            va   = $urandom_range(0, 6);
            htot = hs + ha + $urandom_range(3, 6);
            vtot = vs + va + $urandom_range(1, 3);
            if ($urandom_range(0, 3) == 0) vtot = vs + $urandom_range(0, va);
            frame(per, hs, ha, vs, va, htot, vtot, $urandom_range(0, 7), -1, 1);
        end

        pix_en = 1'b0;
        repeat (4) @(negedge PCLK);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lbuf_wr_ctrl.md
Name: lbuf_wr_ctrl

Overview:
Write-side controller for the 40-entry circular line buffer read by the output sync generator. It tracks the source video timing from the source HSYNC/VSYNC and pixel-enable strobes. It sequences captured active pixels into line-buffer write addresses and wraps the write line pointer modulo the buffer depth. It also flags write/read line collisions against the read-side line index.

Parameters:
NUM_LINE_BUFFERS, 40, line buffer depth; line pointer wraps at NUM_LINE_BUFFERS-1
DATA_W, 12, source pixel width (4:4:4 RGB)
H_CNT_W, 9, source pixel counter width (max 512 pixels/line)
V_CNT_W, 9, source line counter width (max 512 lines/frame)

Ports:
PCLK  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
pix_en  in  1  source pixel strobe; sync inputs and pixel_in are sampled only when high
HSYNC_src  in  1  source horizontal sync, negative polarity
VSYNC_src  in  1  source vertical sync, negative polarity
pixel_in  in  DATA_W  source pixel
h_start  in  H_CNT_W  first captured pixel index after the HSYNC falling edge
h_active  in  H_CNT_W  captured pixels per line
v_start  in  V_CNT_W  first captured line index after the VSYNC falling edge
v_active  in  V_CNT_W  captured lines per frame
rd_line  in  6  line buffer index currently being read by the output side
wr_en  out  1  line buffer write strobe
wr_line  out  6  line buffer write line index
wr_pixel  out  H_CNT_W  pixel address within the line
wr_data  out  DATA_W  write data
frame_start  out  1  one-cycle pulse on a detected VSYNC falling edge
collision  out  1  sticky: write pointer advanced onto rd_line during this frame
busy  out  1  high while state is ACTIVE

Behaviour:
- Reset (synchronous, active-high), one cycle: all outputs 0; state IDLE; internal counters 0; prev_hs=prev_vs=1.
- Edge detect: evaluated only on pix_en cycles. hs_fall = prev_hs & ~HSYNC_src; vs_fall likewise. prev_* update only on pix_en.
- hcnt_src: set to 0 on hs_fall, otherwise +1 per pix_en; saturates at all-ones.
- vcnt_src: set to 0 on vs_fall; otherwise +1 on hs_fall; saturates.
- If vs_fall and hs_fall occur in the same pix_en cycle, vs_fall wins: vcnt_src=0, hcnt_src=0.
- States:
  - IDLE: wait for vs_fall -> VBLANK.
  - VBLANK: on the hs_fall that makes vcnt_src == v_start -> ACTIVE, with wr_line=0.
  - ACTIVE: capture. On each hs_fall, advance wr_line to (wr_line==NUM_LINE_BUFFERS-1) ? 0 : wr_line+1, except on the hs_fall that enters ACTIVE. After the line at vcnt_src == v_start+v_active-1 ends (next hs_fall) -> DONE, with no pointer advance.
  - DONE: wait for vs_fall -> VBLANK.
  - vs_fall in any non-IDLE state forces VBLANK, including mid-ACTIVE. A partial line is abandoned without a pointer advance.
- v_active==0: VBLANK goes directly to DONE; no writes are issued.
- Capture window: in ACTIVE, a pix_en cycle with h_start <= hcnt_src < h_start+h_active (compare at H_CNT_W+1 bits) registers a write.
  - Next cycle: wr_en=1, wr_pixel = hcnt_src - h_start, wr_data = pixel_in.
  - Latency is exactly 1 PCLK. wr_en is a single-cycle pulse per captured pixel.
  - wr_pixel, wr_data and wr_line hold their values while wr_en=0.
- Config inputs h_start/h_active/v_start/v_active are latched on vs_fall and are used for the whole frame.
- frame_start: high for exactly the cycle after the pix_en cycle in which vs_fall is detected.
- collision: set when a wr_line advance produces a value equal to rd_line (rd_line sampled in the same cycle). Cleared on vs_fall; a set on the same edge loses to the clear.
- busy = (state == ACTIVE), registered.

Test Plan:
- Reset mid-ACTIVE (reset high 1 cycle) -> next cycle all outputs 0, state IDLE; no wr_en until vs_fall plus v_start lines.
- pix_en every cycle, h_start=10, h_active=4, v_start=2, v_active=3 -> per frame 12 wr_en pulses: wr_pixel 0..3 on wr_line 0,1,2; first pulse 1 cycle after hcnt_src==10 of line 2; busy drops after line 4.
- pix_en every 4th cycle -> same addresses as previous scenario; wr_en pulses 4 cycles apart; sync edges between strobes ignored until the next strobe.
- v_active=45 -> wr_line sequence 0..39,0..4; wraps 39->0; rd_line held at 5 -> collision set at the advance to 5, stays high, clears on next vs_fall.
- vs_fall coincident with hs_fall mid-ACTIVE (line 3 of 10) -> frame_start pulse, state VBLANK, wr_line not advanced, next frame restarts at wr_line 0.
- v_active=0 -> no wr_en for the whole frame, busy stays 0, frame_start still pulses.
